// File: rtl/frame_sync_pkg.sv
// rtl/frame_sync_pkg.sv - shared frame start pattern constants and sync FSM encoding
package frame_sync_pkg;

    localparam int PAT_LEN    = 64;
    localparam int PAT_WORD_W = 16;
    localparam int PAT_IDX_W  = $clog2(PAT_LEN);

    localparam logic [PAT_IDX_W-1:0] PAT_LAST_IDX = PAT_IDX_W'(PAT_LEN - 1);

    localparam logic [PAT_WORD_W-1:0] PAT_HEAD0 = 16'hABCD;
    localparam logic [PAT_WORD_W-1:0] PAT_HEAD1 = 16'hEF89;
    localparam logic [PAT_WORD_W-1:0] PAT_EVEN  = 16'hBDE7;
    localparam logic [PAT_WORD_W-1:0] PAT_ODD   = 16'hF0A5;
    localparam logic [PAT_WORD_W-1:0] PAT_TAIL0 = 16'h4567;
    localparam logic [PAT_WORD_W-1:0] PAT_TAIL1 = 16'h3210;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } sync_state_e;

endpackage

// File: rtl/pattern_word_lut.sv
// rtl/pattern_word_lut.sv - frame start pattern word lookup by index
module pattern_word_lut
    import frame_sync_pkg::*;
(
    input  logic [PAT_IDX_W-1:0]  i_index,
    output logic [PAT_WORD_W-1:0] o_word
);

    // Head and tail words are unique; the middle alternates on index parity.
    always_comb begin
        o_word = PAT_EVEN;
        if (i_index == PAT_IDX_W'(0)) begin
            o_word = PAT_HEAD0;
        end else if (i_index == PAT_IDX_W'(1)) begin
            o_word = PAT_HEAD1;
        end else if (i_index == PAT_IDX_W'(62)) begin
            o_word = PAT_TAIL0;
        end else if (i_index == PAT_IDX_W'(63)) begin
            o_word = PAT_TAIL1;
        end else if (i_index[0]) begin
            o_word = PAT_ODD;
        end
    end

endmodule

// File: rtl/frame_sync_detector.sv
// rtl/frame_sync_detector.sv - hunts for the frame start pattern and forwards one payload frame
module frame_sync_detector
    import frame_sync_pkg::*;
#(
    parameter int FRAME_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [15:0]      i_data,
    input  logic             i_valid,
    output logic [15:0]      o_data,
    output logic             o_valid,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_sync,
    output logic             o_sync_err,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_frame_cnt
);

    // Wide enough to hold FRAME_WORDS itself, so FRAME_WORDS = 1 still gets one bit.
    localparam int               PAY_W    = $clog2(FRAME_WORDS + 1);
    localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(FRAME_WORDS - 1);

    sync_state_e            state_q, state_d;
    logic [PAT_IDX_W-1:0]   idx_q, idx_d;
    logic [PAY_W-1:0]       pay_cnt_q, pay_cnt_d;
    logic [15:0]            data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   sof_q, sof_d;
    logic                   eof_q, eof_d;
    logic                   sync_q, sync_d;
    logic                   sync_err_q, sync_err_d;
    logic                   locked_q, locked_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [PAT_WORD_W-1:0]  exp_word;

    pattern_word_lut u_pattern_word_lut (
        .i_index (idx_q),
        .o_word  (exp_word)
    );

    // Next-state and registered-output computation; pulses default low each cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pay_cnt_d   = pay_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        sync_d      = 1'b0;
        sync_err_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (i_valid) begin
            case (state_q)
                HUNT: begin
                    if (i_data == exp_word) begin
                        if (idx_q == PAT_LAST_IDX) begin
                            sync_d    = 1'b1;
                            state_d   = LOCK;
                            idx_d     = '0;
                            pay_cnt_d = '0;
                            if (frame_cnt_q != {CNT_W{1'b1}}) begin
                                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            idx_d = idx_q + PAT_IDX_W'(1);
                        end
                    end else begin
                        // HEAD0 occurs only at index 0, so it is the sole restart point.
                        idx_d      = (i_data == PAT_HEAD0) ? PAT_IDX_W'(1) : '0;
                        sync_err_d = (idx_q >= PAT_IDX_W'(2));
                    end
                end
                LOCK: begin
                    valid_d = 1'b1;
                    data_d  = i_data;
                    sof_d   = (pay_cnt_q == '0);
                    if (pay_cnt_q == PAY_LAST) begin
                        eof_d     = 1'b1;
                        state_d   = HUNT;
                        pay_cnt_d = '0;
                    end else begin
                        pay_cnt_d = pay_cnt_q + PAY_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Locked spans the sync cycle through the eof cycle inclusive.
    always_comb begin
        locked_d = (state_d == LOCK) || eof_d;
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            pay_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            sync_q      <= 1'b0;
            sync_err_q  <= 1'b0;
            locked_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pay_cnt_q   <= pay_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            sync_q      <= sync_d;
            sync_err_q  <= sync_err_d;
            locked_q    <= locked_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_sof       = sof_q;
    assign o_eof       = eof_q;
    assign o_sync      = sync_q;
    assign o_sync_err  = sync_err_q;
    assign o_locked    = locked_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_sync_detector.sv
// tb/tb_frame_sync_detector.sv - directed self-checking bench for frame_sync_detector
module tb_frame_sync_detector;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_eof;
    logic        o_sync;
    logic        o_sync_err;
    logic        o_locked;
    logic [15:0] o_frame_cnt;

    int checks = 0;
    int errors = 0;
    int sync_seen = 0;
    int err_seen = 0;
    int valid_seen = 0;

    logic [15:0] pat [64];

    frame_sync_detector #(.FRAME_WORDS(4), .CNT_W(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .o_sync      (o_sync),
        .o_sync_err  (o_sync_err),
        .o_locked    (o_locked),
        .o_frame_cnt (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (o_sync)     sync_seen++;
        if (o_sync_err) err_seen++;
        if (o_valid)    valid_seen++;
    end

    task automatic send(input logic [15:0] d);
        i_data  = d;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_pat(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send(pat[k]);
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_data  = 16'h0000;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_sof, o_eof, o_sync, o_sync_err, o_locked} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {o_valid, o_sof, o_eof, o_sync, o_sync_err, o_locked});
        end
        checks++;
        if (o_data !== 16'h0 || o_frame_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs data=%h cnt=%0d want 0/0", o_data, o_frame_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sync_payload();
        int s0;
        s0 = sync_seen;
        send_pat(0, 62);
        checks++;
        if (sync_seen !== s0 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL early_sync syncs=%0d locked=%b want 0/0", sync_seen - s0, o_locked);
        end
        send(pat[63]);
        checks++;
        if (o_sync !== 1'b1 || o_locked !== 1'b1 || o_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL sync1 sync=%b locked=%b cnt=%0d want 1/1/1", o_sync, o_locked, o_frame_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            send(16'(k + 1));
            checks++;
            if (o_valid !== 1'b1 || o_data !== 16'(k + 1) || o_sof !== (k == 0) || o_eof !== (k == 3) || o_sync !== 1'b0) begin
                errors++;
                $display("FAIL payload1[%0d] v=%b d=%h sof=%b eof=%b want 1/%h/%b/%b", k, o_valid, o_data, o_sof, o_eof, 16'(k + 1), k == 0, k == 3);
            end
        end
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL locked_at_eof got %b want 1", o_locked);
        end
        idle(1);
        checks++;
        if (o_locked !== 1'b0 || o_valid !== 1'b0 || o_data !== 16'h0004) begin
            errors++;
            $display("FAIL after_eof locked=%b v=%b d=%h want 0/0/0004", o_locked, o_valid, o_data);
        end
    endtask

    task automatic test_sync_err();
        int s0;
        int e0;
        s0 = sync_seen;
        e0 = err_seen;
        send_pat(0, 29);
        send(16'h0000);
        checks++;
        if (o_sync_err !== 1'b1) begin
            errors++;
            $display("FAIL err_at_30 got %b want 1", o_sync_err);
        end
        send_pat(31, 63);
        checks++;
        if (sync_seen !== s0 || err_seen !== e0 + 1) begin
            errors++;
            $display("FAIL corrupted_pat syncs=%0d errs=%0d want 0/1", sync_seen - s0, err_seen - e0);
        end
        send_pat(0, 63);
        checks++;
        if (o_sync !== 1'b1 || o_frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL resync sync=%b cnt=%0d want 1/2", o_sync, o_frame_cnt);
        end
        for (int k = 0; k < 4; k++) send(16'h1000 + 16'(k));
        checks++;
        if (o_eof !== 1'b1 || o_data !== 16'h1003) begin
            errors++;
            $display("FAIL payload2_eof eof=%b d=%h want 1/1003", o_eof, o_data);
        end
    endtask

    task automatic test_restart();
        int e0;
        e0 = err_seen;
        send_pat(0, 9);
        send(16'hABCD);
        checks++;
        if (o_sync_err !== 1'b1) begin
            errors++;
            $display("FAIL err_at_10 got %b want 1", o_sync_err);
        end
        send_pat(1, 63);
        checks++;
        if (o_sync !== 1'b1 || o_frame_cnt !== 16'd3 || err_seen !== e0 + 1) begin
            errors++;
            $display("FAIL restart_sync sync=%b cnt=%0d errs=%0d want 1/3/1", o_sync, o_frame_cnt, err_seen - e0);
        end
        for (int k = 0; k < 4; k++) send(16'h2000 + 16'(k));
    endtask

    task automatic test_gaps();
        int s0;
        int e0;
        int v0;
        for (int k = 0; k < 64; k++) begin
            if (k == 0 || k == 31 || k == 63) begin
                s0 = sync_seen;
                e0 = err_seen;
                v0 = valid_seen;
                idle(3);
                checks++;
                if (sync_seen !== s0 || err_seen !== e0 || valid_seen !== v0) begin
                    errors++;
                    $display("FAIL gap_at_%0d sync=%0d err=%0d valid=%0d want 0/0/0", k, sync_seen - s0, err_seen - e0, valid_seen - v0);
                end
            end
            send(pat[k]);
        end
        checks++;
        if (o_sync !== 1'b1 || o_frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL gap_sync sync=%b cnt=%0d want 1/4", o_sync, o_frame_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                v0 = valid_seen;
                idle(3);
                checks++;
                if (valid_seen !== v0 || o_locked !== 1'b1 || o_data !== 16'h0002) begin
                    errors++;
                    $display("FAIL payload_gap valid=%0d locked=%b d=%h want 0/1/0002", valid_seen - v0, o_locked, o_data);
                end
            end
            send(16'(k + 1));
            checks++;
            if (o_valid !== 1'b1 || o_data !== 16'(k + 1) || o_sof !== (k == 0) || o_eof !== (k == 3)) begin
                errors++;
                $display("FAIL payload_gaps[%0d] v=%b d=%h sof=%b eof=%b", k, o_valid, o_data, o_sof, o_eof);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pl [4];
        int s0;
        pl[0] = 16'hABCD; pl[1] = 16'hEF89; pl[2] = 16'hBDE7; pl[3] = 16'hF0A5;
        do_reset();
        send_pat(0, 63);
        checks++;
        if (o_sync !== 1'b1 || o_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL b2b_sync1 sync=%b cnt=%0d want 1/1", o_sync, o_frame_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            send(pl[k]);
            checks++;
            if (o_valid !== 1'b1 || o_data !== pl[k] || o_sof !== (k == 0) || o_eof !== (k == 3)) begin
                errors++;
                $display("FAIL b2b_payload[%0d] v=%b d=%h want 1/%h", k, o_valid, o_data, pl[k]);
            end
        end
        s0 = sync_seen;
        send_pat(0, 62);
        checks++;
        if (sync_seen !== s0) begin
            errors++;
            $display("FAIL b2b_early got %0d syncs want 0", sync_seen - s0);
        end
        send(pat[63]);
        checks++;
        if (o_sync !== 1'b1 || o_frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_sync2 sync=%b cnt=%0d want 1/2", o_sync, o_frame_cnt);
        end
        for (int k = 0; k < 4; k++) send(16'h3000 + 16'(k));
    endtask

    task automatic test_mid_reset();
        int v0;
        send_pat(0, 63);
        send(16'h0001);
        send(16'h0002);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'h0002 || o_frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL pre_reset v=%b d=%h cnt=%0d want 1/0002/3", o_valid, o_data, o_frame_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_sof, o_eof, o_sync, o_sync_err, o_locked} !== 6'b0 || o_data !== 16'h0 || o_frame_cnt !== 16'h0) begin
            errors++;
            $display("FAIL async_reset flags=%b d=%h cnt=%0d want 0", {o_valid, o_sof, o_eof, o_sync, o_sync_err, o_locked}, o_data, o_frame_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_seen;
        send(16'h0003);
        send(16'h0004);
        idle(1);
        checks++;
        if (valid_seen !== v0 || o_eof !== 1'b0 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL post_reset valid=%0d eof=%b locked=%b want 0/0/0", valid_seen - v0, o_eof, o_locked);
        end
        send_pat(0, 63);
        checks++;
        if (o_sync !== 1'b1 || o_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_sync sync=%b cnt=%0d want 1/1", o_sync, o_frame_cnt);
        end
        send(16'h0055);
        checks++;
        if (o_valid !== 1'b1 || o_sof !== 1'b1 || o_data !== 16'h0055) begin
            errors++;
            $display("FAIL post_reset_sof v=%b sof=%b d=%h want 1/1/0055", o_valid, o_sof, o_data);
        end
    endtask

    initial begin
        pat[0]  = 16'hABCD;
        pat[1]  = 16'hEF89;
        for (int k = 2; k <= 61; k++) pat[k] = (k % 2 == 0) ? 16'hBDE7 : 16'hF0A5;
        pat[62] = 16'h4567;
        pat[63] = 16'h3210;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = 16'h0000;
        @(negedge clk);
        test_reset();
        test_sync_payload();
        test_sync_err();
        test_restart();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sync_detector.md
Name: frame_sync_detector

Overview:
Receive-side counterpart of the frame start pattern source. It scans an incoming 16-bit word stream for the 64-word frame start pattern and declares sync when all 64 words match in order. It then forwards exactly FRAME_WORDS payload words with start/end markers and returns to hunting. It sits between the deserialiser word output and the frame payload consumer.

Parameters:
FRAME_WORDS, 256, payload words forwarded after each detected pattern (range 1..65535)
CNT_W, 16, width of the frame counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_data  in  16  received word
i_valid  in  1  i_data qualifier; one word accepted per cycle when high
o_data  out  16  payload word, registered
o_valid  out  1  o_data qualifier
o_sof  out  1  first payload word of frame (coincident with o_valid)
o_eof  out  1  last payload word of frame (coincident with o_valid)
o_sync  out  1  one-cycle pulse: pattern fully matched
o_sync_err  out  1  one-cycle pulse: partial pattern (index >= 2) aborted by mismatch
o_locked  out  1  high while forwarding payload
o_frame_cnt  out  CNT_W  count of detected patterns, saturating

Behaviour:
- Pattern, index 0..63: 0 = 16'hABCD, 1 = 16'hEF89, even 2..60 = 16'hBDE7, odd 3..61 = 16'hF0A5, 62 = 16'h4567, 63 = 16'h3210.
- Reset (async, i_rst_n low): state HUNT, idx = 0, payload count = 0, all outputs 0, o_frame_cnt = 0. Outputs stay 0 while reset is held. Operation resumes on the first edge after deassertion.
- State machine:
  - HUNT, accepted word (i_valid = 1):
    - Word equals pattern[idx] and idx < 63: idx += 1.
    - Word equals pattern[63] at idx = 63: o_sync pulses next cycle, o_frame_cnt += 1 (holds at all-ones), idx <- 0, state -> LOCK.
    - Mismatch: idx <- 1 if word == 16'hABCD, else 0. o_sync_err pulses next cycle if idx was >= 2.
    - ABCD appears only at index 0, so this restart rule is a complete overlap recovery; no other restart point exists.
  - LOCK, accepted word: word is forwarded. Next cycle, o_valid = 1 and o_data = word. o_sof is set on payload word 0; o_eof is set on payload word FRAME_WORDS-1.
    - When word FRAME_WORDS-1 is accepted: state -> HUNT, payload count <- 0.
    - FRAME_WORDS = 1: o_sof and o_eof are set together.
    - Pattern words inside the payload are not interpreted.
- o_locked: 1 from the cycle o_sync is high until the cycle o_eof is high (inclusive).
- i_valid low: no state change. All pulse outputs and o_valid are 0 the next cycle. o_data holds its last value.
- Latency: fixed one cycle from accepted word to o_valid/o_sync/o_sync_err. No backpressure.
- A word accepted in the cycle after LOCK ends is evaluated in HUNT against pattern[0]. Back-to-back frames therefore need no gap.
- Mid-operation reset: the frame is abandoned. No o_eof is generated, and the counter is cleared.
- Payload counter width: ceil(log2(FRAME_WORDS+1)), compared against FRAME_WORDS-1.

Decomposition:
- Shared package frame_sync_pkg:
  - PAT_LEN = 64, PAT_WORD_W = 16
  - constants PAT_HEAD0 = 16'hABCD, PAT_HEAD1 = 16'hEF89, PAT_EVEN = 16'hBDE7, PAT_ODD = 16'hF0A5, PAT_TAIL0 = 16'h4567, PAT_TAIL1 = 16'h3210
  - state encoding HUNT/LOCK
- One sub-module: pattern_word_lut. Combinational index[5:0] -> expected word[15:0], built from the package constants so the transmitter and receiver share one definition.
- Top contains the FSM, idx counter, payload counter and output registers.

Test Plan:
1. FRAME_WORDS = 4. Send 64 pattern words, then 16'h0001..16'h0004 continuous -> o_sync one cycle after word 63. o_data 1,2,3,4 with o_sof on 1 and o_eof on 4. o_frame_cnt = 1, o_locked low after the eof cycle.
2. Pattern with word 30 replaced by 16'h0000 -> o_sync_err pulse one cycle after that word, no o_sync, idx back to 0. A following clean pattern syncs normally.
3. Pattern aborted at index 10 by 16'hABCD, followed by pattern words 1..63 -> o_sync_err once, then o_sync one cycle after the final 16'h3210 (restart-at-1 recovery).
4. Clean pattern with i_valid low for 3 cycles at indices 0, 31 and 63, and during payload -> sync and payload identical to scenario 1. No spurious o_valid during gaps.
5. FRAME_WORDS = 4. Payload words are 16'hABCD, 16'hEF89, 16'hBDE7, 16'hF0A5, then a full pattern follows immediately -> payload forwarded unchanged, second o_sync exactly 64 accepted words after o_eof, o_frame_cnt = 2.
6. Assert i_rst_n low asynchronously after payload word 2 -> all outputs 0 immediately, o_frame_cnt = 0. Payload words after release are not forwarded until a new full pattern.
